rs_queue: RTL
=============

Name: rs_queue

Overview:
- Generic reservation station; the receiving end of the dispatch→RS interface (instantiated once each for ALU, branch and LSU).
- Accepts one `renamed_instr_t` per cycle from dispatch, tracks source-operand readiness, snoops CDB wakeups, and issues one ready instruction per cycle to its functional unit via a valid/ready handshake.
- Drives the `full` backpressure that dispatch uses combinationally.

Parameters:
- `DEPTH`, 8, number of entries; power of two, 2..16.
- `PREG_W`, 6, physical register tag width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  mispredict flush; invalidates every entry.
- `dispatch_en`  in  1  write `dispatch_instr` this cycle.
- `dispatch_instr`  in  `renamed_instr_t`  incoming instruction; uses fields `prs1`, `prs2`, `prd`, `rob_tag`.
- `src1_ready_in`  in  1  busy-table readiness of `prs1` at dispatch.
- `src2_ready_in`  in  1  busy-table readiness of `prs2` at dispatch.
- `rs_full`  out  1  no free entry; to dispatch.
- `cdb_valid`  in  1  completion broadcast valid.
- `cdb_tag`  in  `PREG_W`  physical register being written.
- `issue_valid`  out  1  `issue_instr` is ready to issue.
- `issue_instr`  out  `renamed_instr_t`  selected entry payload.
- `issue_ready`  in  1  FU accepts this cycle.
- `occupancy`  out  `$clog2(DEPTH)+1`  number of valid entries.

Behaviour:
- **Per-entry state** (all registered): `valid`, `rdy1`, `rdy2`, payload.
- **Reset (`rst`=1 at edge):** all `valid`=0; hence `rs_full`=0, `issue_valid`=0, `occupancy`=0, `issue_instr`=0. Reset mid-stream discards every entry; there is no drain.
- **`rs_full`:** combinational from registered state only, equal to (`occupancy`==`DEPTH`). It must not depend on `dispatch_en`, `issue_ready` or `cdb_*` (no loop with dispatch).
- **Allocation:**
  - On `dispatch_en` && !`rs_full` && !`flush`, write the lowest-index invalid entry at the edge.
  - Set `rdy1` = `src1_ready_in` | (`cdb_valid` && `cdb_tag`==`prs1`); likewise `rdy2` from `src2_ready_in` and `prs2` (same-cycle wakeup bypass).
  - `dispatch_en` while `rs_full` is a protocol violation. It is ignored: no entry is overwritten, `occupancy` is unchanged.
  - A slot freed by issue in the same cycle is not reusable until the next cycle.
- **Wakeup:** each cycle with `cdb_valid`, every valid entry whose `prs1`/`prs2` equals `cdb_tag` sets `rdy1`/`rdy2` at the edge. Ready bits never clear except on deallocation.
- **Select:**
  - `issue_valid` = OR over entries of (`valid` && `rdy1` && `rdy2`).
  - `issue_instr` = payload of the lowest-index such entry. When `issue_valid`=0, `issue_instr` is 0.
  - Combinational from registered state. A wakeup arriving in cycle t makes the entry eligible in cycle t+1, never in t.
- **Issue:**
  - On `issue_valid` && `issue_ready` && !`flush`, the selected entry's `valid` clears at the edge.
  - `issue_instr` is held stable while `issue_valid` && !`issue_ready`, unless a lower-index entry becomes ready. Re-selection is permitted; the FU samples only on the handshake.
- **Minimum latency:** dispatch at edge t, both sources ready → `issue_valid`=1 in cycle t+1.
- **Simultaneous dispatch + issue:**
  - Both take effect; `occupancy` is unchanged.
  - If the freed index equals the lowest free index, allocation uses the next free index, computed from pre-edge state (never the same slot).
- **Flush:** priority over dispatch, issue and wakeup. At the edge all `valid`=0, `occupancy`=0.
- **`occupancy`:** registered, = popcount(`valid`). Updated +1 / −1 / 0 per allocate/free; never exceeds `DEPTH`.
- **Tag 0:** `cdb_tag`=0 is treated like any other tag. The rename stage guarantees p0 sources arrive with `src*_ready_in`=1.
- Payload bits other than the ready bits are never modified after allocation.

Test Plan:
- **Reset + single issue:** reset, dispatch `rob_tag`=3, both ready, `issue_ready`=1 → `issue_valid`=1 exactly one cycle later with `rob_tag`=3; `occupancy` 0→1→0.
- **Wakeup + bypass:**
  - Dispatch A with `prs1`=12 not ready → no issue.
  - Pulse `cdb_tag`=12 → A issues the following cycle.
  - Dispatch B with `prs2`=20 not ready in the same cycle as `cdb_tag`=20 → B issues next cycle, not later.
- **Full:**
  - Dispatch 8 ready instructions with `issue_ready`=0 → `rs_full`=1 after the 8th, `occupancy`=8.
  - A 9th `dispatch_en` changes nothing.
  - Raise `issue_ready` for 1 cycle → `rs_full`=0 next cycle.
- **Simultaneous:** at `occupancy`=4, dispatch + issue handshake in the same cycle → `occupancy` stays 4, no entry lost or duplicated (scoreboard of `rob_tag`s).
- **Ordering/backpressure:**
  - Entries 0,1,2 hold `rob_tag`s 5,6,7; only 1 and 2 ready, `issue_ready`=0 for 3 cycles → `issue_instr.rob_tag`=6 stable.
  - Then issues 6, then 7.
- **Flush:** 5 entries valid, assert `flush` together with `dispatch_en`, a CDB hit and `issue_ready` → next cycle `occupancy`=0, `issue_valid`=0, `rs_full`=0, no handshake counted.

Source files
------------

// File: rtl/rs_queue.sv
// rs_queue: generic reservation station. Holds renamed instructions until
// both sources are ready, snoops the CDB, and issues one per cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             invalidate every entry (mispredict)
//   dispatch_en       write dispatch_instr into the lowest free entry
//   dispatch_instr    incoming renamed instruction
//   src1/2_ready_in   busy-table readiness of prs1/prs2 at dispatch
//   rs_full           no free entry (registered state only)
//   cdb_valid/tag     completion broadcast for wakeup
//   issue_valid/instr lowest-index ready entry
//   issue_ready       functional unit accepts this cycle
//   occupancy         number of valid entries

package rs_pkg;
    localparam int PREG_BITS = 6;
    localparam int ROB_BITS  = 5;

    typedef struct packed {
        logic [PREG_BITS-1:0] prs1;
        logic [PREG_BITS-1:0] prs2;
        logic [PREG_BITS-1:0] prd;
        logic [ROB_BITS-1:0]  rob_tag;
    } renamed_instr_t;
endpackage

module rs_queue
    import rs_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PREG_W = PREG_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   dispatch_en,
    input  renamed_instr_t         dispatch_instr,
    input  logic                   src1_ready_in,
    input  logic                   src2_ready_in,
    output logic                   rs_full,
    input  logic                   cdb_valid,
    input  logic [PREG_W-1:0]      cdb_tag,
    output logic                   issue_valid,
    output renamed_instr_t         issue_instr,
    input  logic                   issue_ready,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rdy1_q;
    logic [DEPTH-1:0] rdy2_q;
    renamed_instr_t   payload_q [DEPTH];
    logic [OCC_W-1:0] occ_q;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             din_hit1;
    logic             din_hit2;
    logic             alloc;
    logic             fire;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && rdy1_q[i] && rdy2_q[i];
            hit1[i] = cdb_valid
                && (cdb_tag == PREG_W'(payload_q[i].prs1));
            hit2[i] = cdb_valid
                && (cdb_tag == PREG_W'(payload_q[i].prs2));
        end
    end

    // Free slot and issue slot both come from pre-edge state, so a slot
    // freed by issue this cycle (still valid) is never picked for alloc.
    always_comb begin
        logic free_found;
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!sel_found && ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign din_hit1 = cdb_valid
        && (cdb_tag == PREG_W'(dispatch_instr.prs1));
    assign din_hit2 = cdb_valid
        && (cdb_tag == PREG_W'(dispatch_instr.prs2));

    assign rs_full     = (occ_q == OCC_W'(DEPTH));
    assign issue_valid = sel_found;
    assign issue_instr = sel_found ? payload_q[sel_idx] : '0;
    assign occupancy   = occ_q;

    assign alloc = dispatch_en && !rs_full && !flush;
    assign fire  = sel_found && issue_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            occ_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && hit1[i]) rdy1_q[i] <= 1'b1;
                if (valid_q[i] && hit2[i]) rdy2_q[i] <= 1'b1;
            end
            if (fire) begin
                valid_q[sel_idx] <= 1'b0;
                rdy1_q[sel_idx]  <= 1'b0;
                rdy2_q[sel_idx]  <= 1'b0;
            end
            if (alloc) begin
                valid_q[free_idx]   <= 1'b1;
                payload_q[free_idx] <= dispatch_instr;
                rdy1_q[free_idx]    <= src1_ready_in | din_hit1;
                rdy2_q[free_idx]    <= src2_ready_in | din_hit2;
            end
            occ_q <= occ_q + OCC_W'(alloc) - OCC_W'(fire);
        end
    end

endmodule
